fp_addsub_seq: RTL and testbench

//  Parametrised multi-cycle IEEE-754 adder/subtractor; next generation of the FP32 adder datapath.

---
 rtl/floatingpointpkg.sv | 37 +++
 rtl/fp_lzc.sv | 21 ++
 rtl/fp_addsub_seq.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/floatingpointpkg.sv
// Shared floating-point types: operand classification and adder/subtractor sequencing states.
package floatingpointpkg;

    typedef enum logic [2:0] {
        ZERO,
        SUBN,
        NORM,
        INF,
        NAN
    } fp_class_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } fpadd_state_e;

    // Width-agnostic: callers pass the field predicates rather than the fields themselves.
    function automatic fp_class_e fpClassify(
        input logic expZero,
        input logic expOnes,
        input logic fracNonZero,
        input logic denormEn
    );
        if (expOnes) begin
            return fracNonZero ? NAN : INF;
        end else if (expZero) begin
            return (denormEn && fracNonZero) ? SUBN : ZERO;
        end
        return NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]           Value,
    output logic [$clog2(WIDTH+1)-1:0] Count
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Scan upward so the highest set bit is the last one to write Count.
    always_comb begin
        Count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (Value[i]) begin
                Count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor with round-to-nearest-even, one operation in flight.
// Define FPADD_DENORM_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fp_addsub_seq
    import floatingpointpkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [EXP_W+FRAC_W:0] InA,
    input  logic [EXP_W+FRAC_W:0] InB,
    input  logic                  Op,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [EXP_W+FRAC_W:0] Result,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  Zero,
    output logic                  Inf,
    output logic                  Nan,
    output logic                  Inexact
);

    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int MW  = FRAC_W + 4;
    localparam int SW  = FRAC_W + 5;
    localparam int XW  = EXP_W + 1;
    localparam int LZW = $clog2(MW + 1);
    localparam int CW  = ((XW > LZW) ? XW : LZW) + 1;
    localparam logic [31:0]      SH_MAX   = 32'(FRAC_W + 3);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [XW-1:0]    EXP_MAX  = {1'b0, EXP_ONES};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
`ifdef FPADD_DENORM_EN
    localparam logic DENORM_EN = 1'b1;
`else
    localparam logic DENORM_EN = 1'b0;
`endif

    fpadd_state_e stateReg;
    logic inReadyReg, outValidReg, zeroReg, infReg, nanReg, inexactReg;
    logic [W-1:0] resultReg;

    logic [W-1:0] aReg, bReg;
    logic opReg;
    logic uSignA, uSignB, uSpec;
    logic [XW-1:0] uExpA, uExpB;
    logic [FRAC_W:0] uManA, uManB;
    logic [W-1:0] uSpecVal;
    logic alSign, alSub, alZeroNeg;
    logic [XW-1:0] alExp;
    logic [MW-1:0] alBig, alSmall;
    logic [SW-1:0] sumReg;
    logic [XW-1:0] adExp;
    logic adSign, adZeroNeg;
    logic [MW-1:0] nmMant;
    logic [XW-1:0] nmExp;
    logic nmSign, nmZero, nmFlush, nmZeroNeg;
    logic [W-1:0] rdResult;
    logic rdInexact;

    // Unpack: classification and special-value override.
    logic [EXP_W-1:0] expFldA, expFldB;
    logic [FRAC_W-1:0] fracA, fracB;
    logic signBEff;
    fp_class_e classA, classB;
    logic [XW-1:0] unpExpA, unpExpB;
    logic [FRAC_W:0] unpManA, unpManB;
    logic unpSpec;
    logic [W-1:0] unpSpecVal;

    assign expFldA  = aReg[W-2:FRAC_W];
    assign expFldB  = bReg[W-2:FRAC_W];
    assign fracA    = aReg[FRAC_W-1:0];
    assign fracB    = bReg[FRAC_W-1:0];
    assign signBEff = bReg[W-1] ^ opReg;
    assign classA   = fpClassify(expFldA == '0, expFldA == EXP_ONES, |fracA, DENORM_EN);
    assign classB   = fpClassify(expFldB == '0, expFldB == EXP_ONES, |fracB, DENORM_EN);

    always_comb begin
        unpExpA = (expFldA == '0) ? XW'(1) : {1'b0, expFldA};
        unpExpB = (expFldB == '0) ? XW'(1) : {1'b0, expFldB};
        unpManA = '0;
        unpManB = '0;
        if (classA == NORM) unpManA = {1'b1, fracA};
        else if (classA == SUBN) unpManA = {1'b0, fracA};
        if (classB == NORM) unpManB = {1'b1, fracB};
        else if (classB == SUBN) unpManB = {1'b0, fracB};
        unpSpec    = 1'b1;
        unpSpecVal = QNAN;
        if (classA == NAN || classB == NAN ||
            (classA == INF && classB == INF && aReg[W-1] != signBEff)) begin
            unpSpecVal = QNAN;
        end else if (classA == INF) begin
            unpSpecVal = {aReg[W-1], EXP_ONES, {FRAC_W{1'b0}}};
        end else if (classB == INF) begin
            unpSpecVal = {signBEff, EXP_ONES, {FRAC_W{1'b0}}};
        end else begin
            unpSpec = 1'b0;
        end
    end

    // Align: the smaller magnitude shifts right, everything past the round bit folds into sticky.
    logic aIsBig;
    logic [XW-1:0] bigExp, smallExp, expDiff;
    logic [FRAC_W:0] bigMan, smallMan;
    logic [31:0] shAmt;
    logic [MW-1:0] smallExt, smallShift, lostMask, alnSmall;

    always_comb begin
        aIsBig     = (uExpA > uExpB) || ((uExpA == uExpB) && (uManA >= uManB));
        bigExp     = aIsBig ? uExpA : uExpB;
        smallExp   = aIsBig ? uExpB : uExpA;
        bigMan     = aIsBig ? uManA : uManB;
        smallMan   = aIsBig ? uManB : uManA;
        expDiff    = bigExp - smallExp;
        shAmt      = (32'(expDiff) > SH_MAX) ? SH_MAX : 32'(expDiff);
        smallExt   = {smallMan, 3'b000};
        smallShift = smallExt >> shAmt;
        lostMask   = ~({MW{1'b1}} << shAmt);
        alnSmall   = {smallShift[MW-1:1], smallShift[0] | (|(smallExt & lostMask))};
    end

    logic [SW-1:0] sumNext;
    assign sumNext = alSub ? ({1'b0, alBig} - {1'b0, alSmall}) : ({1'b0, alBig} + {1'b0, alSmall});

    // Normalise; an exponent that would drop below 1 either goes subnormal or flushes.
    logic [LZW-1:0] lzCount;
    logic [CW-1:0] lzWide, expWide;
    logic [MW-1:0] normMant;
    logic [XW-1:0] normExp;
    logic normZero, normFlush;

    fp_lzc #(.WIDTH(MW)) uLzc (
        .Value (sumReg[MW-1:0]),
        .Count (lzCount)
    );

    assign lzWide  = {{(CW-LZW){1'b0}}, lzCount};
    assign expWide = {{(CW-XW){1'b0}}, adExp};

    always_comb begin
        normMant  = sumReg[MW-1:0];
        normExp   = adExp;
        normZero  = 1'b0;
        normFlush = 1'b0;
        if (sumReg == '0) begin
            normZero = 1'b1;
        end else if (sumReg[SW-1]) begin
            normMant = {sumReg[SW-1:2], |sumReg[1:0]};
            normExp  = adExp + XW'(1);
        end else if (lzWide < expWide) begin
            normMant = sumReg[MW-1:0] << lzCount;
            normExp  = XW'(expWide - lzWide);
        end else if (DENORM_EN) begin
            normMant = sumReg[MW-1:0] << (adExp - XW'(1));
            normExp  = '0;
        end else begin
            normFlush = 1'b1;
        end
    end

    // Round to nearest even; a subnormal that rounds up into the hidden bit becomes exponent 1.
    logic roundInc;
    logic [FRAC_W+1:0] rounded;
    logic [XW-1:0] expRnd;
    logic [FRAC_W-1:0] fracRnd;
    logic [W-1:0] roundResult;
    logic roundInexact;

    always_comb begin
        roundInc = nmMant[2] & ((|nmMant[1:0]) | nmMant[3]);
        rounded  = {1'b0, nmMant[MW-1:3]} + {{(FRAC_W+1){1'b0}}, roundInc};
        if (nmExp == '0) begin
            expRnd = {{EXP_W{1'b0}}, rounded[FRAC_W]};
        end else begin
            expRnd = nmExp + {{EXP_W{1'b0}}, rounded[FRAC_W+1]};
        end
        fracRnd = rounded[FRAC_W+1] ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
        roundResult  = {nmSign, expRnd[EXP_W-1:0], fracRnd};
        roundInexact = |nmMant[2:0];
        if (uSpec) begin
            roundResult  = uSpecVal;
            roundInexact = 1'b0;
        end else if (nmZero) begin
            roundResult  = {nmZeroNeg, {(W-1){1'b0}}};
            roundInexact = 1'b0;
        end else if (nmFlush) begin
            roundResult  = {nmSign, {(W-1){1'b0}}};
            roundInexact = 1'b1;
        end else if (expRnd >= EXP_MAX) begin
            roundResult  = {nmSign, EXP_ONES, {FRAC_W{1'b0}}};
            roundInexact = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        case (stateReg)
            S_IDLE: begin
                if (InValid && inReadyReg) begin
                    aReg  <= InA;
                    bReg  <= InB;
                    opReg <= Op;
                end
            end
            S_UNPACK: begin
                uSignA   <= aReg[W-1];
                uSignB   <= signBEff;
                uExpA    <= unpExpA;
                uExpB    <= unpExpB;
                uManA    <= unpManA;
                uManB    <= unpManB;
                uSpec    <= unpSpec;
                uSpecVal <= unpSpecVal;
            end
            S_ALIGN: begin
                alSign    <= aIsBig ? uSignA : uSignB;
                alExp     <= bigExp;
                alBig     <= {bigMan, 3'b000};
                alSmall   <= alnSmall;
                alSub     <= uSignA ^ uSignB;
                alZeroNeg <= uSignA & uSignB;
            end
            S_ADD: begin
                sumReg    <= sumNext;
                adExp     <= alExp;
                adSign    <= alSign;
                adZeroNeg <= alZeroNeg;
            end
            S_NORM: begin
                nmMant    <= normMant;
                nmExp     <= normExp;
                nmSign    <= adSign;
                nmZero    <= normZero;
                nmFlush   <= normFlush;
                nmZeroNeg <= adZeroNeg;
            end
            S_ROUND: begin
                rdResult  <= roundResult;
                rdInexact <= roundInexact;
            end
            default: ;
        endcase
    end

    logic [EXP_W-1:0] rdExp;
    logic rdFracNz;
    assign rdExp    = rdResult[W-2:FRAC_W];
    assign rdFracNz = |rdResult[FRAC_W-1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg    <= S_IDLE;
            inReadyReg  <= 1'b1;
            outValidReg <= 1'b0;
            resultReg   <= '0;
            zeroReg     <= 1'b0;
            infReg      <= 1'b0;
            nanReg      <= 1'b0;
            inexactReg  <= 1'b0;
        end else begin
            case (stateReg)
                S_IDLE: begin
                    if (InValid && inReadyReg) begin
                        inReadyReg <= 1'b0;
                        stateReg   <= S_UNPACK;
                    end
                end
                S_UNPACK: stateReg <= S_ALIGN;
                S_ALIGN:  stateReg <= S_ADD;
                S_ADD:    stateReg <= S_NORM;
                S_NORM:   stateReg <= S_ROUND;
                S_ROUND:  stateReg <= S_DONE;
                S_DONE: begin
                    // First DONE edge publishes the result; later edges wait for the consumer.
                    if (!outValidReg) begin
                        outValidReg <= 1'b1;
                        resultReg   <= rdResult;
                        zeroReg     <= (rdExp == '0) && !rdFracNz;
                        infReg      <= (rdExp == EXP_ONES) && !rdFracNz;
                        nanReg      <= (rdExp == EXP_ONES) && rdFracNz;
                        inexactReg  <= rdInexact;
                    end else if (OutReady) begin
                        outValidReg <= 1'b0;
                        inReadyReg  <= 1'b1;
                        stateReg    <= S_IDLE;
                    end
                end
                default: stateReg <= S_IDLE;
            endcase
        end
    end

    assign InReady  = inReadyReg;
    assign OutValid = outValidReg;
    assign Result   = resultReg;
    assign Zero     = zeroReg;
    assign Inf      = infReg;
    assign Nan      = nanReg;
    assign Inexact  = inexactReg;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq at FP32 widths; expected results are hand-derived constants.
module tb_fp_addsub_seq;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] InA, InB;
    logic        Op, InValid, InReady;
    logic [31:0] Result;
    logic        OutValid, OutReady;
    logic        Zero, Inf, Nan, Inexact;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    exp_t sbQ[$];

    fp_addsub_seq #(.EXP_W(8), .FRAC_W(23)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InA      (InA),
        .InB      (InB),
        .Op       (Op),
        .InValid  (InValid),
        .InReady  (InReady),
        .Result   (Result),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Zero     (Zero),
        .Inf      (Inf),
        .Nan      (Nan),
        .Inexact  (Inexact)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operation, scrambles the inputs after acceptance, returns edges until OutValid (-1 on timeout).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op, output int lat);
        int waitCnt;
        waitCnt = 0;
        InA = a; InB = b; Op = op; InValid = 1'b1;
        while (!InReady && waitCnt < 20) begin
            @(posedge Clock); #1;
            waitCnt++;
        end
        if (!InReady) begin
            InValid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge Clock); #1;
        InValid = 1'b0;
        InA = $urandom; InB = $urandom; Op = 1'($urandom_range(0, 1));
        lat = 0;
        while (!OutValid && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
        if (!OutValid) lat = -1;
    endtask

    task automatic handoff();
        OutReady = 1'b1;
        @(posedge Clock); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({InReady, OutValid, Result, Zero, Inf, Nan, Inexact} !== {1'b1, 1'b0, 32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h flags=%b, expected rdy=1 vld=0 res=00000000 flags=0000",
                     InReady, OutValid, Result, {Zero, Inf, Nan, Inexact});
        end
        $display("txn reset: rdy=%b vld=%b res=%h", InReady, OutValid, Result);
    endtask

    task automatic test_arith();
        vec_t vecs[$];
        exp_t e;
        int   lat;
        vecs.push_back(vec_t'{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000});
        vecs.push_back(vec_t'{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b1000});
        vecs.push_back(vec_t'{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b1000});
        vecs.push_back(vec_t'{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b1000});
        vecs.push_back(vec_t'{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b1000});
        vecs.push_back(vec_t'{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
        vecs.push_back(vec_t'{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0010});
        vecs.push_back(vec_t'{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010});
        vecs.push_back(vec_t'{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b0010});
        vecs.push_back(vec_t'{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0100});
        vecs.push_back(vec_t'{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
        vecs.push_back(vec_t'{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001});
        vecs.push_back(vec_t'{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001});
        vecs.push_back(vec_t'{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000});
        vecs.push_back(vec_t'{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000});
        vecs.push_back(vec_t'{32'h40400000, 32'h3F000000, 1'b0, 32'h40600000, 4'b0000});
`ifdef FPADD_DENORM_EN
        vecs.push_back(vec_t'{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000});
        vecs.push_back(vec_t'{32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000});
        vecs.push_back(vec_t'{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0001});
`else
        vecs.push_back(vec_t'{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b1000});
        vecs.push_back(vec_t'{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b1001});
        vecs.push_back(vec_t'{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000});
`endif
        foreach (vecs[i]) begin
            sbQ.push_back(exp_t'{vecs[i].res, vecs[i].fl});
            issue(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            e = sbQ.pop_front();
            $display("txn arith %0d: %h %s %h -> %h flags=%b lat=%0d", i, vecs[i].a,
                     vecs[i].op ? "-" : "+", vecs[i].b, Result, {Zero, Inf, Nan, Inexact}, lat);
            checks++;
            if (lat !== 6) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d edges, expected 6", i, lat);
            end
            checks++;
            if (Result !== e.res) begin
                errors++;
                $display("FAIL arith_result[%0d]: got %h, expected %h", i, Result, e.res);
            end
            checks++;
            if ({Zero, Inf, Nan, Inexact} !== e.fl) begin
                errors++;
                $display("FAIL arith_flags[%0d]: got %b, expected %b (Z I N X)", i, {Zero, Inf, Nan, Inexact}, e.fl);
            end
            handoff();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        sbQ.push_back(exp_t'{32'h40400000, 4'b0000});
        issue(32'h3F800000, 32'h40000000, 1'b0, lat);
        e = sbQ.pop_front();
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL b2b_latency0: got %0d edges, expected 6", lat);
        end
        // A second request waits while the first result is held back.
        InA = 32'h40000000; InB = 32'h40000000; Op = 1'b0; InValid = 1'b1;
        sbQ.push_back(exp_t'{32'h40800000, 4'b0000});
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #1;
            checks++;
            if ({OutValid, InReady, Result} !== {1'b1, 1'b0, e.res}) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: got vld=%b rdy=%b res=%h, expected vld=1 rdy=0 res=%h",
                         c, OutValid, InReady, Result, e.res);
            end
        end
        $display("txn b2b first: res=%h flags=%b", Result, {Zero, Inf, Nan, Inexact});
        checks++;
        if ({Zero, Inf, Nan, Inexact} !== e.fl) begin
            errors++;
            $display("FAIL b2b_flags0: got %b, expected %b", {Zero, Inf, Nan, Inexact}, e.fl);
        end
        handoff();
        checks++;
        if ({OutValid, InReady} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_handoff: got vld=%b rdy=%b, expected vld=0 rdy=1", OutValid, InReady);
        end
        @(posedge Clock); #1;
        checks++;
        if (InReady !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got rdy=%b, expected 0", InReady);
        end
        InValid = 1'b0;
        InA = $urandom;
        lat = 0;
        while (!OutValid && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
        e = sbQ.pop_front();
        $display("txn b2b second: res=%h lat=%0d", Result, lat);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL b2b_latency1: got %0d edges, expected 6", lat);
        end
        checks++;
        if (Result !== e.res) begin
            errors++;
            $display("FAIL b2b_result1: got %h, expected %h", Result, e.res);
        end
        handoff();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        bit   sawValid;
        InA = 32'h3F800000; InB = 32'h3F800000; Op = 1'b0; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        checks++;
        if ({OutValid, InReady, Result} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL midreset_state: got vld=%b rdy=%b res=%h, expected vld=0 rdy=1 res=00000000",
                     OutValid, InReady, Result);
        end
        sawValid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clock); #1;
            if (OutValid) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: got OutValid=1 after reset, expected 0");
        end
        $display("txn midreset: vld=%b rdy=%b", OutValid, InReady);
        sbQ.push_back(exp_t'{32'h40000000, 4'b0000});
        issue(32'h40400000, 32'h3F800000, 1'b1, lat);
        e = sbQ.pop_front();
        $display("txn midreset recovery: res=%h lat=%0d", Result, lat);
        checks++;
        if ({lat == 6, Result} !== {1'b1, e.res}) begin
            errors++;
            $display("FAIL midreset_recover: got res=%h lat=%0d, expected res=%h lat=6", Result, lat, e.res);
        end
        handoff();
    endtask

    initial begin
        Reset = 1'b1; InA = '0; InB = '0; Op = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        test_reset();
        Reset = 1'b0;
        @(posedge Clock); #1;
        test_arith();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
